// File: rtl/rf_pkg.sv
// Shared defaults and requester indices for the register-file write arbiter.
// Imported by the arbiter top and by anything that needs requester numbering.
package rf_pkg;

  localparam int RF_DATA_WIDTH    = 16;
  localparam int RF_ADDRESS_WIDTH = 4;
  localparam int RF_NUM_REQ       = 4;

  localparam int REQ_ALU = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_SHF = 2;
  localparam int REQ_DAG = 3;

  // The round-robin pointer moves one past the winner and wraps at n.
  function automatic int rf_next_idx(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: scans req from ptr upwards with
// wrap-around and returns the first hit as a one-hot vector and an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;
  int   cand;

  // Offset k walks the requesters in priority order starting at ptr.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the single regfile write port between the compute-unit requesters and
// flags read-after-write hazards for the two operand read addresses.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int NUM_REQ       = RF_NUM_REQ
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_vld,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_wadd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_dt,
  output logic [NUM_REQ-1:0]               req_gnt,
  output logic                             rf_w_en,
  output logic [ADDRESS_WIDTH-1:0]         rf_wadd,
  output logic [DATA_WIDTH-1:0]            rf_wdt,
  input  logic [ADDRESS_WIDTH-1:0]         rd_raddx,
  input  logic [ADDRESS_WIDTH-1:0]         rd_raddy,
  output logic                             hz_x,
  output logic                             hz_y,
  output logic                             busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]            r_ptr;
  logic                     r_wEn;
  logic [ADDRESS_WIDTH-1:0] r_wAdd;
  logic [DATA_WIDTH-1:0]    r_wDt;

  logic                     w_arbEn;
  logic [NUM_REQ-1:0]       w_gnt;
  logic [PW-1:0]            w_gIdx;
  logic                     w_anyGnt;
  logic [ADDRESS_WIDTH-1:0] w_waddArr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_dtArr   [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0] w_selWadd;
  logic [DATA_WIDTH-1:0]    w_selDt;
  logic                     w_hzReqX;
  logic                     w_hzReqY;

  assign w_arbEn = rst_n & ~hold;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req (req_vld),
    .ptr (r_ptr),
    .en  (w_arbEn),
    .gnt (w_gnt),
    .idx (w_gIdx)
  );

  assign w_anyGnt = |w_gnt;
  assign req_gnt  = w_gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_waddArr[i] = req_wadd[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      w_dtArr[i]   = req_dt[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The grant is one-hot, so an AND-OR mux picks the winner's address and data.
  always_comb begin
    w_selWadd = '0;
    w_selDt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_selWadd = w_selWadd | w_waddArr[i];
        w_selDt   = w_selDt | w_dtArr[i];
      end
    end
  end

  // Address and data hold their last value when no write is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_wEn  <= 1'b0;
      r_wAdd <= '0;
      r_wDt  <= '0;
    end else begin
      r_wEn <= w_anyGnt;
      if (w_anyGnt) begin
        r_ptr  <= PW'(rf_next_idx(int'(w_gIdx), NUM_REQ));
        r_wAdd <= w_selWadd;
        r_wDt  <= w_selDt;
      end
    end
  end

  assign rf_w_en = r_wEn;
  assign rf_wadd = r_wAdd;
  assign rf_wdt  = r_wDt;

  // Any requester still pending (granted now or not) is a hazard, because the
  // regfile read is asynchronous and that write only lands at a later edge.
  always_comb begin
    w_hzReqX = 1'b0;
    w_hzReqY = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_vld[i] && (w_waddArr[i] == rd_raddx)) w_hzReqX = 1'b1;
      if (req_vld[i] && (w_waddArr[i] == rd_raddy)) w_hzReqY = 1'b1;
    end
  end

  assign hz_x = rst_n & ((r_wEn && (r_wAdd == rd_raddx)) || w_hzReqX);
  assign hz_y = rst_n & ((r_wEn && (r_wAdd == rd_raddy)) || w_hzReqY);
  assign busy = rst_n & ((|req_vld) || r_wEn);

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected regfile writes go into a queue
// that a monitor drains whenever the write port fires.
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [3:0]  req_vld;
  logic [15:0] req_wadd;
  logic [63:0] req_dt;
  logic [3:0]  req_gnt;
  logic        rf_w_en;
  logic [3:0]  rf_wadd;
  logic [15:0] rf_wdt;
  logic [3:0]  rd_raddx;
  logic [3:0]  rd_raddy;
  logic        hz_x;
  logic        hz_y;
  logic        busy;

  logic [3:0]  tbWadd [4];
  logic [15:0] tbDt   [4];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t expQ [$];
  int  testsRun  = 0;
  int  failCount = 0;

  assign req_wadd = {tbWadd[3], tbWadd[2], tbWadd[1], tbWadd[0]};
  assign req_dt   = {tbDt[3], tbDt[2], tbDt[1], tbDt[0]};

  rf_wr_arbiter #(
    .DATA_WIDTH    (16),
    .ADDRESS_WIDTH (4),
    .NUM_REQ       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .req_vld  (req_vld),
    .req_wadd (req_wadd),
    .req_dt   (req_dt),
    .req_gnt  (req_gnt),
    .rf_w_en  (rf_w_en),
    .rf_wadd  (rf_wadd),
    .rf_wdt   (rf_wdt),
    .rd_raddx (rd_raddx),
    .rd_raddy (rd_raddy),
    .hz_x     (hz_x),
    .hz_y     (hz_y),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every write seen on the regfile port must match the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && rf_w_en === 1'b1) begin
      testsRun++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", rf_wadd, rf_wdt);
      end else begin
        e = expQ.pop_front();
        if (rf_wadd !== e.addr || rf_wdt !== e.data) begin
          failCount++;
          $display("[TB] FAIL rf_write: got addr=%h data=%h, required addr=%h data=%h",
                   rf_wadd, rf_wdt, e.addr, e.data);
        end
      end
    end
  end

  // A requester must keep vld up until it has been granted.
  logic [3:0] pVld = 4'b0;
  logic [3:0] pGnt = 4'b0;
  logic       pRst = 1'b0;
  always @(negedge clk) begin
    if (pRst === 1'b1 && rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        assert (!(pVld[i] && !pGnt[i] && !req_vld[i]))
          else $error("[TB] protocol violation: requester %0d dropped vld before grant", i);
      end
    end
    pVld = req_vld;
    pGnt = req_gnt;
    pRst = rst_n;
  end

  // Drives one cycle's control inputs just after the edge, then waits for the
  // opposite edge so the caller can check settled outputs.
  task automatic applyStimulus(input logic r, input logic h, input logic [3:0] v);
    @(posedge clk);
    #1;
    rst_n   = r;
    hold    = h;
    req_vld = v;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pushWrite(input logic [3:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  initial begin
    rst_n    = 1'b0;
    hold     = 1'b0;
    req_vld  = 4'b1111;
    rd_raddx = 4'h1;
    rd_raddy = 4'h2;
    tbWadd[REQ_ALU] = 4'h1; tbDt[REQ_ALU] = 16'h1111;
    tbWadd[REQ_MUL] = 4'h2; tbDt[REQ_MUL] = 16'h2222;
    tbWadd[REQ_SHF] = 4'h3; tbDt[REQ_SHF] = 16'h3333;
    tbWadd[REQ_DAG] = 4'h4; tbDt[REQ_DAG] = 16'h4444;

    // Reset held two cycles with every requester asking.
    applyStimulus(1'b0, 1'b0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    checkOutput("reset_gnt",  32'(req_gnt), 32'h0);
    checkOutput("reset_wen",  32'(rf_w_en), 32'h0);
    checkOutput("reset_wadd", 32'(rf_wadd), 32'h0);
    checkOutput("reset_wdt",  32'(rf_wdt),  32'h0);
    checkOutput("reset_busy", 32'(busy),    32'h0);
    checkOutput("reset_hzx",  32'(hz_x),    32'h0);

    // Round robin from ptr=0; each requester drops after its grant.
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkOutput("rr_gnt0", 32'(req_gnt), 32'h1);
    checkOutput("rr_hzx",  32'(hz_x),    32'h1);
    pushWrite(4'h1, 16'h1111);
    applyStimulus(1'b1, 1'b0, 4'b1110);
    checkOutput("rr_gnt1", 32'(req_gnt), 32'h2);
    checkOutput("rr_wen1", 32'(rf_w_en), 32'h1);
    pushWrite(4'h2, 16'h2222);
    applyStimulus(1'b1, 1'b0, 4'b1100);
    checkOutput("rr_gnt2", 32'(req_gnt), 32'h4);
    pushWrite(4'h3, 16'h3333);
    applyStimulus(1'b1, 1'b0, 4'b1000);
    checkOutput("rr_gnt3", 32'(req_gnt), 32'h8);
    checkOutput("rr_wen3", 32'(rf_w_en), 32'h1);
    pushWrite(4'h4, 16'h4444);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("rr_idle_gnt",  32'(req_gnt), 32'h0);
    checkOutput("rr_idle_busy", 32'(busy),    32'h1);
    tbWadd[REQ_SHF] = 4'h7; tbDt[REQ_SHF] = 16'hBEEF;
    rd_raddx = 4'h5; rd_raddy = 4'h6;

    // Single requester: SHF alone, ptr=0 so it wins straight away.
    applyStimulus(1'b1, 1'b0, 4'b0100);
    checkOutput("single_gnt",  32'(req_gnt), 32'h4);
    checkOutput("single_wen0", 32'(rf_w_en), 32'h0);
    pushWrite(4'h7, 16'hBEEF);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("single_wen1", 32'(rf_w_en), 32'h1);
    checkOutput("single_wadd", 32'(rf_wadd), 32'h7);
    checkOutput("single_wdt",  32'(rf_wdt),  32'hBEEF);
    tbWadd[REQ_ALU] = 4'h8; tbDt[REQ_ALU] = 16'h8888;
    tbWadd[REQ_MUL] = 4'h9; tbDt[REQ_MUL] = 16'h9999;
    tbWadd[REQ_DAG] = 4'hC; tbDt[REQ_DAG] = 16'hCCCC;
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("single_wen2",  32'(rf_w_en), 32'h0);
    checkOutput("single_wadd_hold", 32'(rf_wadd), 32'h7);

    // ptr=3: MUL wins by wrap-around, leaving ptr=2 for the fairness run.
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput("wrap_gnt", 32'(req_gnt), 32'h2);
    pushWrite(4'h9, 16'h9999);
    applyStimulus(1'b1, 1'b0, 4'b1011);
    checkOutput("fair_gnt3", 32'(req_gnt), 32'h8);
    pushWrite(4'hC, 16'hCCCC);
    applyStimulus(1'b1, 1'b0, 4'b1011);
    checkOutput("fair_gnt0", 32'(req_gnt), 32'h1);
    pushWrite(4'h8, 16'h8888);
    applyStimulus(1'b1, 1'b0, 4'b1010);
    checkOutput("fair_gnt1", 32'(req_gnt), 32'h2);
    pushWrite(4'h9, 16'h9999);
    applyStimulus(1'b1, 1'b0, 4'b1000);
    checkOutput("fair_gnt3b", 32'(req_gnt), 32'h8);
    pushWrite(4'hC, 16'hCCCC);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput("fair_gnt0b", 32'(req_gnt), 32'h1);
    pushWrite(4'h8, 16'h8888);

    // hold with everyone asking: no grants, ptr stays at 1.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 4'b1111);
      checkOutput("hold_gnt",  32'(req_gnt), 32'h0);
      checkOutput("hold_busy", 32'(busy),    32'h1);
    end
    rd_raddx = 4'h9;
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkOutput("hold_release_gnt", 32'(req_gnt), 32'h2);
    checkOutput("hold_release_hzx", 32'(hz_x),    32'h1);

    // Reset right after a grant: combinational outputs gated, write port cleared.
    applyStimulus(1'b0, 1'b0, 4'b1101);
    checkOutput("midrst_gnt",  32'(req_gnt), 32'h0);
    checkOutput("midrst_busy", 32'(busy),    32'h0);
    checkOutput("midrst_hzx",  32'(hz_x),    32'h0);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("postrst_wen",  32'(rf_w_en), 32'h0);
    checkOutput("postrst_wadd", 32'(rf_wadd), 32'h0);
    checkOutput("postrst_busy", 32'(busy),    32'h0);
    tbWadd[REQ_MUL] = 4'hA; tbDt[REQ_MUL] = 16'hAAAA;
    tbWadd[REQ_ALU] = 4'h3; tbDt[REQ_ALU] = 16'h0303;
    tbWadd[REQ_SHF] = 4'h3; tbDt[REQ_SHF] = 16'h0505;
    rd_raddx = 4'hA; rd_raddy = 4'h5;

    // Hazard: pending request, then registered write, then clear.
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput("hz_req_gnt", 32'(req_gnt), 32'h2);
    checkOutput("hz_req_x",   32'(hz_x),    32'h1);
    checkOutput("hz_req_y",   32'(hz_y),    32'h0);
    pushWrite(4'hA, 16'hAAAA);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("hz_wr_x", 32'(hz_x), 32'h1);
    checkOutput("hz_wr_y", 32'(hz_y), 32'h0);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("hz_clear_x", 32'(hz_x), 32'h0);

    // Same destination from SHF and ALU: ptr=2 so SHF lands first, ALU wins last.
    applyStimulus(1'b1, 1'b0, 4'b0101);
    checkOutput("samedst_gnt_shf", 32'(req_gnt), 32'h4);
    pushWrite(4'h3, 16'h0505);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput("samedst_gnt_alu", 32'(req_gnt), 32'h1);
    pushWrite(4'h3, 16'h0303);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("drain_busy1", 32'(busy), 32'h1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("drain_busy0",   32'(busy),        32'h0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
Shares the single register-file write port between NUM_REQ compute-unit requesters (ALU, MUL, SHF, DAG) using round-robin arbitration.
- Registers the granted write onto the regfile write port (xb_rf_w_En / ps_xb_wadd / xb_rf_dt side).
- Provides combinational read-after-write hazard flags for the two regfile read addresses, so the sequencer can stall operand fetch.
- Sits between the compute units and the crossbar in front of the regfile.

Parameters:
- DATA_WIDTH, 16, regfile data width
- ADDRESS_WIDTH, 4, regfile address width (2**ADDRESS_WIDTH registers)
- NUM_REQ, 4, number of write requesters (2..8)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- hold  in  1  freeze arbitration (no grants while 1)
- req_vld  in  NUM_REQ  per-requester write request
- req_wadd  in  NUM_REQ*ADDRESS_WIDTH  per-requester destination register, requester i at slice i
- req_dt  in  NUM_REQ*DATA_WIDTH  per-requester write data, requester i at slice i
- req_gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accept
- rf_w_en  out  1  registered regfile write enable
- rf_wadd  out  ADDRESS_WIDTH  registered regfile write address
- rf_wdt  out  DATA_WIDTH  registered regfile write data
- rd_raddx  in  ADDRESS_WIDTH  regfile read address X being fetched
- rd_raddy  in  ADDRESS_WIDTH  regfile read address Y being fetched
- hz_x  out  1  pending write to rd_raddx
- hz_y  out  1  pending write to rd_raddy
- busy  out  1  any req_vld high or rf_w_en high

Behaviour:
- Reset (rst_n=0 at a rising edge): rf_w_en=0, rf_wadd=0, rf_wdt=0, priority pointer ptr=0. req_gnt, hz_x, hz_y and busy are combinational and are all 0 while rst_n=0.
- Handshake: requester i raises req_vld[i] and holds wadd/dt stable until it sees req_gnt[i]=1 in a cycle. The transfer completes at that cycle's rising edge. Deasserting vld before grant is a protocol violation; the bench flags it with an assertion.
- Grant: combinational.
  - Search req_vld starting at index ptr, ascending with wrap-around.
  - The first set bit gets req_gnt; at most one bit is set.
  - No grant when hold=1, when rst_n=0, or when req_vld=0.
- Pointer: on a grant to index g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Write port: latency 1.
  - On a grant edge: rf_w_en<=1, rf_wadd<=req_wadd[g], rf_wdt<=req_dt[g].
  - Otherwise rf_w_en<=0; rf_wadd and rf_wdt hold their last values.
  - Maximum one write per cycle. Back-to-back grants give continuous rf_w_en.
- Fairness: a requester with continuously asserted vld (hold=0) is granted within NUM_REQ cycles.
- Same-destination requests: writes land in grant order. The last granted value wins in the regfile.
- Hazards (the regfile read is asynchronous and the write lands at the next edge):
  - hz_x = (rf_w_en && rf_wadd==rd_raddx) OR (some i with req_vld[i] && req_wadd[i]==rd_raddx).
  - hz_y is the same expression using rd_raddy.
  - This includes a requester granted this cycle.
- hold: asserted mid-stream, it gives no grant that cycle. rf_w_en may still be 1 from the previous cycle's grant; that write completes. ptr is frozen while hold=1.
- Reset mid-operation: an in-flight registered write is dropped (rf_w_en forced 0). Requesters must re-present after reset.
- No other state; no FSM beyond ptr and the output register.

Decomposition:
- Package rf_pkg:
  - DATA_WIDTH/ADDRESS_WIDTH defaults
  - NUM_REQ default
  - requester index constants REQ_ALU=0, REQ_MUL=1, REQ_SHF=2, REQ_DAG=3
- Sub-module rr_arbiter (parameter N):
  - inputs: req, ptr, en
  - outputs: one-hot gnt and encoded index
  - purely combinational; ptr update stays in rf_wr_arbiter.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all req_vld=4'b1111 -> req_gnt=0, rf_w_en=0, rf_wadd=0, rf_wdt=0. First cycle after release -> req_gnt=4'b0001.
- Single requester: req_vld[2]=1, wadd=4'h7, dt=16'hBEEF -> req_gnt=4'b0100 same cycle. Next cycle rf_w_en=1, rf_wadd=7, rf_wdt=16'hBEEF. The cycle after -> rf_w_en=0.
- Round-robin: all four vld continuously with distinct wadd 1,2,3,4 -> grants 0,1,2,3 on consecutive cycles. rf_w_en high 4 consecutive cycles with wadd 1,2,3,4.
- Fairness after wrap: ptr=2, vld=4'b1011 -> grant order 3,0,1, then 3 again while still valid.
- Hazard: req_vld[1]=1 wadd=4'hA, rd_raddx=4'hA, rd_raddy=4'h5 -> hz_x=1, hz_y=0. Next cycle (rf_w_en, wadd=A) -> hz_x=1. Following cycle with no requests -> hz_x=0.
- hold/reset mid-stream: all vld, hold=1 for 3 cycles -> no grants, ptr frozen, busy=1. Reset asserted the cycle after a grant -> rf_w_en=0 the next cycle, no write issued.
